// File: rtl/qram_arb_pkg.sv
// Shared types and constants for the QSPI RAM arbiter/sequencer.
package qram_arb_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRdata,
        StWdata,
        StDone,
        StInit,
        StInitGap
    } state_e;

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } port_e;

    localparam int unsigned CmdNibbles  = 2;
    localparam int unsigned AddrNibbles = 6;
    localparam int unsigned DataNibbles = 2;

    localparam logic [7:0] CmdReadDefault  = 8'h0B;
    localparam logic [7:0] CmdWriteDefault = 8'h02;
    localparam logic [7:0] CmdEnterQpi     = 8'h35;

    // Address nibble idx (0 = addr[23:20]) for MSB-first transmission.
    function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [2:0] idx);
        logic [23:0] s;
        s = addr << {idx, 2'b00};
        return s[23:20];
    endfunction

endpackage

// File: rtl/qram_rr_arb.sv
// Two-way round-robin arbiter; grants only while en_i (sequencer idle) is high.
module qram_rr_arb
    import qram_arb_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  logic  req_a_i,
    input  logic  req_b_i,
    output logic  gnt_o,
    output port_e gnt_port_o
);

    port_e last_q;

    always_comb begin
        gnt_o = en_i && (req_a_i || req_b_i);
        if (req_a_i && req_b_i) begin
            gnt_port_o = (last_q == PortA) ? PortB : PortA;
        end else if (req_a_i) begin
            gnt_port_o = PortA;
        end else begin
            gnt_port_o = PortB;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PortB;
        end else if (gnt_o) begin
            last_q <= gnt_port_o;
        end
    end

endmodule

// File: rtl/qram_arbiter.sv
// Two-port arbiter and QPI byte sequencer for the external QSPI RAM.
// Define QRAM_ARB_ENTER_QPI_EN to send the SPI enter-QPI command (0x35) after reset.
module qram_arbiter
    import qram_arb_pkg::*;
#(
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter logic [7:0]  CMD_READ     = CmdReadDefault,
    parameter logic [7:0]  CMD_WRITE    = CmdWriteDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [23:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [23:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    input  logic [3:0]  io_in
);

`ifdef QRAM_ARB_ENTER_QPI_EN
    localparam state_e ResetState = StInit;
`else
    localparam state_e ResetState = StIdle;
`endif

    localparam logic [7:0] DummyLast = (DUMMY_CYCLES > 0) ? 8'(DUMMY_CYCLES - 1) : 8'd0;

    state_e      state_q, state_d, next_after;
    logic        phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d, last_idx;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    port_e       port_q, port_d;
    logic [3:0]  hi_q, hi_d;
    logic [7:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic        gnt;
    port_e       gnt_port;
    logic [7:0]  opcode, init_sh;

    qram_rr_arb u_arb (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (state_q == StIdle),
        .req_a_i    (a_req),
        .req_b_i    (b_req),
        .gnt_o      (gnt),
        .gnt_port_o (gnt_port)
    );

    assign opcode = we_q ? CMD_WRITE : CMD_READ;

    always_comb begin
        last_idx   = 8'd0;
        next_after = StIdle;
        case (state_q)
            StCmd: begin
                last_idx   = 8'(CmdNibbles - 1);
                next_after = StAddr;
            end
            StAddr: begin
                last_idx = 8'(AddrNibbles - 1);
                if (we_q) begin
                    next_after = StWdata;
                end else begin
                    next_after = (DUMMY_CYCLES > 0) ? StDummy : StRdata;
                end
            end
            StDummy: begin
                last_idx   = DummyLast;
                next_after = StRdata;
            end
            StRdata, StWdata: begin
                last_idx   = 8'(DataNibbles - 1);
                next_after = StDone;
            end
            StInit: begin
                last_idx   = 8'd7;
                next_after = StInitGap;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        port_d    = port_q;
        hi_d      = hi_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            StIdle: begin
                if (gnt) begin
                    port_d  = gnt_port;
                    we_d    = (gnt_port == PortA) ? a_we : b_we;
                    addr_d  = (gnt_port == PortA) ? a_addr : b_addr;
                    wdata_d = (gnt_port == PortA) ? a_wdata : b_wdata;
                    phase_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = StCmd;
                end
            end
            StDone, StInitGap: state_d = StIdle;
            default: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == last_idx) begin
                        cnt_d   = 8'd0;
                        state_d = next_after;
                    end
                    // Device drives during phase 1; capture at the end of it.
                    if (state_q == StRdata) begin
                        if (cnt_q == 8'd0) begin
                            hi_d = io_in;
                        end else if (port_q == PortA) begin
                            a_rdata_d = {hi_q, io_in};
                        end else begin
                            b_rdata_d = {hi_q, io_in};
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ResetState;
            phase_q   <= 1'b0;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= 24'd0;
            wdata_q   <= 8'd0;
            port_q    <= PortB;
            hi_q      <= 4'd0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            port_q    <= port_d;
            hi_q      <= hi_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        cs_n    = 1'b1;
        sclk    = 1'b0;
        io_out  = 4'h0;
        io_oe   = 4'h0;
        init_sh = CmdEnterQpi << cnt_q[2:0];
        case (state_q)
            StCmd: begin
                cs_n   = 1'b0;
                sclk   = phase_q;
                io_oe  = 4'hF;
                io_out = cnt_q[0] ? opcode[3:0] : opcode[7:4];
            end
            StAddr: begin
                cs_n   = 1'b0;
                sclk   = phase_q;
                io_oe  = 4'hF;
                io_out = addr_nibble(addr_q, cnt_q[2:0]);
            end
            StDummy, StRdata: begin
                cs_n = 1'b0;
                sclk = phase_q;
            end
            StWdata: begin
                cs_n   = 1'b0;
                sclk   = phase_q;
                io_oe  = 4'hF;
                io_out = cnt_q[0] ? wdata_q[3:0] : wdata_q[7:4];
            end
            StInit: begin
                cs_n   = 1'b0;
                sclk   = phase_q;
                io_oe  = 4'b0001;
                io_out = {3'b000, init_sh[7]};
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign a_ack   = (state_q == StDone) && (port_q == PortA);
    assign b_ack   = (state_q == StDone) && (port_q == PortB);
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_qram_arbiter.sv
// Directed bench for qram_arbiter with a behavioural QPI RAM model.
module tb_qram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_we, a_ack, b_req, b_we, b_ack, busy, cs_n, sclk;
    logic [23:0] a_addr, b_addr;
    logic [7:0]  a_wdata, a_rdata, b_wdata, b_rdata;
    logic [3:0]  io_out, io_oe, io_in;

    logic        z_a_req, z_a_ack, z_b_ack, z_busy, z_cs_n, z_sclk;
    logic [7:0]  z_a_rdata, z_b_rdata;
    logic [3:0]  z_io_out, z_io_oe, z_io_in;

    qram_arbiter #(.DUMMY_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .cs_n(cs_n), .sclk(sclk), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
    );

    qram_arbiter #(.DUMMY_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_req(z_a_req), .a_we(1'b0), .a_addr(24'h000010), .a_wdata(8'h00),
        .a_ack(z_a_ack), .a_rdata(z_a_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(24'h000000), .b_wdata(8'h00),
        .b_ack(z_b_ack), .b_rdata(z_b_rdata),
        .busy(z_busy), .cs_n(z_cs_n), .sclk(z_sclk), .io_out(z_io_out), .io_oe(z_io_oe),
        .io_in(z_io_in)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // QPI RAM model (4 dummy periods): counts sclk rising edges since cs_n fell.
    localparam int D = 4;
    logic [7:0]  mem [logic [23:0]];
    logic [7:0]  nib_q [$];
    int          m_cnt;
    logic [7:0]  m_cmd, m_wd, m_rd;
    logic [23:0] m_addr;

    always @(negedge cs_n) begin
        m_cnt = 0;
        io_in = 4'h0;
        nib_q.delete();
    end

    always @(posedge sclk) begin
        if (!cs_n) begin
            nib_q.push_back({io_oe, io_out});
            if (m_cnt < 2) begin
                m_cmd = {m_cmd[3:0], io_out};
            end else if (m_cnt < 8) begin
                m_addr = {m_addr[19:0], io_out};
            end else if (m_cmd == 8'h02 && m_cnt < 10) begin
                m_wd = {m_wd[3:0], io_out};
                if (m_cnt == 9) mem[m_addr] = m_wd;
            end
            m_cnt++;
            m_rd = mem.exists(m_addr) ? mem[m_addr] : 8'h00;
            if (m_cmd == 8'h0B && m_cnt == 9 + D) io_in = m_rd[7:4];
            else if (m_cmd == 8'h0B && m_cnt == 10 + D) io_in = m_rd[3:0];
            else io_in = 4'h0;
        end
    end

    // Zero-dummy DUT sees the sclk edge count as data: periods 8,9 read back 8'h9A.
    logic [3:0] z_cnt;
    always @(negedge z_cs_n) z_cnt = 4'h0;
    always @(posedge z_sclk) z_cnt = z_cnt + 4'h1;
    assign z_io_in = z_cnt;

    int a_ack_cnt = 0, b_ack_cnt = 0, hi_run = 0, min_gap = 1000;
    bit was_low = 0;
    always @(negedge clk) begin
        if (a_ack) a_ack_cnt++;
        if (b_ack) b_ack_cnt++;
        if (cs_n) begin
            hi_run++;
        end else begin
            if (was_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            hi_run  = 0;
            was_low = 1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef QRAM_ARB_ENTER_QPI_EN
        repeat (17) @(posedge clk);
        #1;
`endif
    endtask

    // Issue one request, return cycles from grant to ack (-1 on timeout); ends in IDLE.
    task automatic do_req(input bit port_b, input bit we, input logic [23:0] addr,
                          input logic [7:0] wd, output int lat);
        if (port_b) begin
            b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end
        lat = -1;
        for (int c = 1; c <= 80 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (port_b ? b_ack : a_ack) lat = c;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_rd [12] = '{8'hF0, 8'hFB, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
                                8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_wr [10] = '{8'hF0, 8'hF2, 8'hF0, 8'hF0, 8'hFF, 8'hFF, 8'hF0, 8'hF0,
                                8'hF3, 8'hFC};

    initial begin
        int lat, a0, b0, n, order[4];
        bit re_a, re_b;
        logic exp_cs, exp_busy;

        rst = 1'b1; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; z_a_req = 0;
        mem[24'h123456] = 8'hA5;

`ifdef QRAM_ARB_ENTER_QPI_EN
        begin
            logic [7:0] ser;
            bit busy_ok, oe_ok;
            ser = 8'h00; busy_ok = 1; oe_ok = 1; lat = -1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            a_we = 1'b0; a_addr = 24'h123456; a_req = 1'b1;
            for (int c = 0; c < 80 && lat < 0; c++) begin
                if (c > 0) begin
                    @(posedge clk);
                    #1;
                end
                if (c < 16) begin
                    if (!busy) busy_ok = 0;
                    if (io_oe != 4'b0001 || cs_n) oe_ok = 0;
                    if (c % 2 == 1) ser = {ser[6:0], io_out[0]};
                end
                if (a_ack) lat = c;
            end
            a_req = 1'b0;
            check_eq("init_serial", ser, 8'h35);
            check_eq("init_busy", busy_ok, 1);
            check_eq("init_oe_cs", oe_ok, 1);
            check_eq("init_req_lat", lat, 46);
            check_eq("init_req_data", a_rdata, 8'hA5);
        end
`endif

        // Reset state
        do_reset();
        check_eq("rst_cs_n", cs_n, 1'b1);
        check_eq("rst_sclk", sclk, 1'b0);
        check_eq("rst_io", {io_oe, io_out}, 8'h00);
        check_eq("rst_acks", {a_ack, b_ack}, 2'b00);
        check_eq("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
        check_eq("rst_busy", busy, 1'b0);

        // Port A read
        b0 = b_ack_cnt;
        do_req(0, 0, 24'h123456, 8'h00, lat);
        check_eq("rd_lat", lat, 29);
        check_eq("rd_data", a_rdata, 8'hA5);
        check_eq("rd_no_back", b_ack_cnt - b0, 0);
        check_eq("rd_nib_cnt", nib_q.size(), 14);
        for (int i = 0; i < 12; i++) check_eq($sformatf("rd_nib%0d", i), nib_q[i], exp_rd[i]);

        // Port B write, then read back through A
        a0 = a_ack_cnt;
        do_req(1, 1, 24'h00FF00, 8'h3C, lat);
        check_eq("wr_lat", lat, 21);
        check_eq("wr_no_a_ack", a_ack_cnt - a0, 0);
        check_eq("wr_nib_cnt", nib_q.size(), 10);
        for (int i = 0; i < 10; i++) check_eq($sformatf("wr_nib%0d", i), nib_q[i], exp_wr[i]);
        a_addr = 24'h000000;
        do_req(0, 0, 24'h00FF00, 8'h00, lat);
        check_eq("wr_rb_lat", lat, 29);
        check_eq("wr_rb_data", a_rdata, 8'h3C);

        // Simultaneous requests, each re-raised after its ack
        do_reset();
        min_gap = 1000; was_low = 0; n = 0; re_a = 0; re_b = 0;
        a_we = 0; a_addr = 24'h123456; b_we = 0; b_addr = 24'h00FF00;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 0; c < 300 && n < 4; c++) begin
            @(posedge clk);
            #1;
            if (re_a) begin a_req = 1'b1; re_a = 0; end
            if (re_b) begin b_req = 1'b1; re_b = 0; end
            if (a_ack) begin order[n] = 0; n++; a_req = 1'b0; re_a = 1; end
            if (b_ack) begin order[n] = 1; n++; b_req = 1'b0; re_b = 1; end
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rr_count", n, 4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("rr_order%0d", i), order[i], i % 2);
        check_eq("rr_gap_ge2", min_gap >= 2, 1);
        check_eq("rr_b_data", b_rdata, 8'h3C);

        // Reset mid-read
        do_reset();
        a0 = a_ack_cnt;
        a_we = 0; a_addr = 24'h123456; a_req = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
`ifdef QRAM_ARB_ENTER_QPI_EN
        exp_cs = 1'b0; exp_busy = 1'b1;
`else
        exp_cs = 1'b1; exp_busy = 1'b0;
`endif
        check_eq("abort_cs_n", cs_n, exp_cs);
        check_eq("abort_busy", busy, exp_busy);
        check_eq("abort_ack", a_ack, 1'b0);
        rst = 1'b0; a_req = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("abort_no_ack", a_ack_cnt - a0, 0);
        check_eq("abort_rdata", a_rdata, 8'h00);
        do_req(0, 0, 24'h123456, 8'h00, lat);
        check_eq("reissue_lat", lat, 29);
        check_eq("reissue_data", a_rdata, 8'hA5);

        // Zero dummy cycles, request dropped at cycle 3
        lat = -1;
        z_a_req = 1'b1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) z_a_req = 1'b0;
            if (z_a_ack) lat = c;
        end
        z_a_req = 1'b0;
        check_eq("d0_lat", lat, 21);
        check_eq("d0_data", z_a_rdata, 8'h9A);
        check_eq("d0_b_ack", z_b_ack, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qram_arbiter.md
Name: qram_arbiter

Overview:
- Two-port arbiter and QSPI sequencer for the external QSPI RAM bus (cs_n, sclk, 4-bit bidirectional IO) on the tt_um_as1802 top level.
- Port A: CPU data accesses. Port B: secondary requester (DMA / UART buffer).
- Arbitrates between the ports, then runs one complete QPI-mode byte transaction per grant: command, 24-bit address, read dummy cycles, data.
- Instantiated alongside the ROM fetch unit, which has its own pins. The upper uio nibble is the RAM bus.

Parameters:
- DUMMY_CYCLES, 4, sclk periods between address and read data (0 allowed: dummy phase skipped).
- CMD_READ, 8'h0B, QPI fast-read opcode.
- CMD_WRITE, 8'h02, QPI write opcode.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  24  port A byte address.
- a_wdata  in  8  port A write data.
- a_ack  out  1  one-cycle completion pulse.
- a_rdata  out  8  port A read data; valid on a_ack, held until next port A read.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- busy  out  1  high whenever the sequencer is not in IDLE.
- cs_n  out  1  RAM chip select, active low.
- sclk  out  1  RAM serial clock.
- io_out  out  4  IO drive value.
- io_oe  out  4  IO output enables.
- io_in  in  4  IO sampled value.

Behaviour:
- Reset values: cs_n=1, sclk=0, io_out=0, io_oe=0, acks=0, rdata=0, busy=0, state=IDLE, last_grant=B. A reset mid-transaction aborts it: cs_n=1 on the next edge, no ack is issued, and the request must be reissued.
- States and order: IDLE -> CMD(2 nibbles) -> ADDR(6) -> DUMMY(DUMMY_CYCLES, read only) -> RDATA(2) or WDATA(2) -> DONE -> IDLE.
- Arbitration, in IDLE only:
  - Only one req high: grant that port.
  - Both high: grant the port not equal to last_grant. last_grant updates on every grant.
  - Grant cycle (T0): latch we/addr/wdata and the granted port id.
- Nibble timing: each nibble or dummy period takes 2 clk.
  - Phase 0: sclk=0, io_out updated.
  - Phase 1: sclk=1; the device samples on the rising edge.
  - cs_n=0 from T1 through the last phase 1.
- Nibble order is MSB first: opcode[7:4], opcode[3:0], addr[23:20] … addr[3:0], data[7:4], data[3:0].
- io_oe: 4'hF in CMD, ADDR and WDATA; 4'h0 in DUMMY and RDATA. io_out=0 whenever io_oe=0.
- Read sampling: io_in is sampled at the end of each RDATA phase-1 cycle, high nibble first.
- Latency: N = 10 + DUMMY_CYCLES for reads, N = 10 for writes. Nibble phases occupy T1..T2N. DONE is T2N+1: cs_n=1, sclk=0, the granted ack pulses, and rdata updates (reads only). Reads with the default parameter complete in 29 cycles; writes complete in 21.
- Back-to-back: the earliest next grant is in the IDLE cycle after DONE, which guarantees cs_n high for at least 2 clk.
- Request rules:
  - Dropping req after the grant does not abort; the ack still pulses.
  - A req held through its own ack cycle is not re-granted in that cycle, because DONE is not IDLE.
  - Address and data changes after the grant are ignored.

Optional Feature:
- Macro: QRAM_ARB_ENTER_QPI_EN.
- Defined:
  - After reset the block enters INIT instead of IDLE, with busy=1.
  - Sends 8'h35 in SPI mode: 8 sclk periods, bit per period, MSB first, on io_out[0], io_oe=4'b0001, cs_n=0. This takes 16 clk, then one cs_n-high cycle, then IDLE.
  - Requests during INIT wait.
- Undefined: the RAM is assumed to be already in QPI mode, and reset goes directly to IDLE.

Decomposition:
- Package qram_arb_pkg: the state enum, the nibble-count constants (CMD=2, ADDR=6, DATA=2), the default opcodes, and the enter-QPI opcode 8'h35.
- One sub-module, qram_rr_arb: the 2-way round-robin arbiter holding last_grant, with grant-enable input from IDLE.

Test Plan:
- Port A read, addr 24'h123456, RAM model returns 8'hA5:
  - io nibbles 0,B,1,2,3,4,5,6 with oe=F, then 4 dummy periods with oe=0.
  - a_ack exactly 29 cycles after the grant, a_rdata=8'hA5, b_ack stays 0.
- Port B write, addr 24'h00FF00, data 8'h3C:
  - Nibbles 0,2,0,0,F,F,0,0,3,C.
  - b_ack at cycle 21; a subsequent port A read of 24'h00FF00 returns 8'h3C.
- a_req and b_req raised in the same cycle after reset, then both re-raised after each ack:
  - Grant order A, B, A, B.
  - cs_n high at least 2 clk between transactions.
- rst pulsed at cycle 10 of a port A read:
  - cs_n=1 the next cycle, no a_ack, busy=0.
  - A reissued read completes normally.
- DUMMY_CYCLES=0 read:
  - No dummy periods, ack at cycle 21.
  - Deasserting a_req at cycle 3 still yields a_ack.
- QRAM_ARB_ENTER_QPI_EN defined:
  - After reset, io_out[0] serialises 0,0,1,1,0,1,0,1 over 16 clk with busy=1.
  - A request made during INIT is granted only after INIT completes.
